// File: rtl/bin_to_bcd_seq_pkg.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - BCD_DIGIT_W : width of one packed BCD digit
//   - state_t     : converter FSM states (encoding 2'd3 is unused)
//   - bcd_digits_ok : true when a digit count can represent every value
//                     of a given binary width (10^digits > 2^width - 1)
// ----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ceil(width * log10(2)) digits are needed to hold 2^width - 1.
    // 30103/100000 approximates log10(2) closely enough for any practical width.
    function automatic bit bcd_digits_ok(input int bin_w, input int digits);
        return digits >= ((bin_w * 30103) + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 cell of the shift-and-add-3 algorithm. A digit of 5 or
// more is pre-corrected by +3 so that the following left shift produces a
// decimal carry into the next digit. The largest input a valid accumulator
// digit can hold is 9, and the result never exceeds 12, so no wrap occurs.
// Ports:
//   i_digit  in   4   BCD digit before the shift
//   o_digit  out  4   adjusted digit
// ----------------------------------------------------------------------------
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A value is accepted in IDLE, shifted through the BCD accumulator over
// BIN_WIDTH clocks, then presented in DONE until the downstream accepts it.
//
// Parameters:
//   BIN_WIDTH   width of the unsigned binary input (>= 4)
//   BCD_DIGITS  number of BCD output digits (>= 1); fewer digits than the
//               input range needs is legal and reported through o_overflow
//
// Ports:
//   i_clk       in   1               system clock
//   i_reset     in   1               synchronous active-high reset
//   i_bin       in   BIN_WIDTH       binary value, sampled on the accept edge
//   i_valid     in   1               input valid
//   o_ready     out  1               converter idle and able to accept
//   o_bcd       out  4*BCD_DIGITS    packed BCD, digit 0 (ones) in [3:0]
//   o_overflow  out  1               result truncated; qualified by o_valid
//   o_valid     out  1               result valid
//   i_ready     in   1               downstream accepts the result
//   o_blank     out  BCD_DIGITS      leading-zero blank mask
//                                    (present only with BIN_TO_BCD_BLANK_EN)
//
// Build option:
//   BIN_TO_BCD_BLANK_EN  adds the o_blank port and its registered mask logic.
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH  = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [BIN_WIDTH-1:0]              i_bin,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] o_bcd,
    output logic                              o_overflow,
    output logic                              o_valid,
    input  logic                              i_ready
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    output logic [BCD_DIGITS-1:0]             o_blank
`endif
);

    localparam int ACC_W = BCD_DIGIT_W * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH);

    // Truncating configurations are allowed (overflow is flagged at run
    // time); only structurally impossible sizes are rejected here.
    localparam bit LOSSLESS = bcd_digits_ok(BIN_WIDTH, BCD_DIGITS);

    generate
        if (BIN_WIDTH < 4) begin : g_bad_width
            $error("bin_to_bcd_seq: BIN_WIDTH must be at least 4");
        end
        if (BCD_DIGITS < 1) begin : g_bad_digits
            $error("bin_to_bcd_seq: BCD_DIGITS must be at least 1");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;

    logic [BIN_WIDTH-1:0] r_shift;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_shifting;
    logic                 w_last;
    logic [ACC_W-1:0]     w_adj;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_carry;

    // ------------------------------------------------------------------
    // Add-3 correction of every accumulator digit ahead of the shift
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // {acc, shift} move left one bit; the bit leaving the top digit is a
    // decimal carry that has no digit to land in.
    assign w_carry    = w_adj[ACC_W-1];
    assign w_acc_next = {w_adj[ACC_W-2:0], r_shift[BIN_WIDTH-1]};

    assign w_accept   = (r_state == ST_IDLE) && i_valid;
    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = (r_cnt == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                // 2'd3 is unreachable in normal operation; recover to IDLE
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of the state register)
    // ------------------------------------------------------------------
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            ST_IDLE: o_ready = 1'b1;
            ST_DONE: o_valid = 1'b1;
            default: begin
                o_ready = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion datapath: loaded on accept, advanced once per SHIFT clock.
    // Its contents are only observed through the result registers, so it
    // needs no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_shift <= i_bin;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(BIN_WIDTH - 1);
        end else if (w_shifting) begin
            r_shift <= {r_shift[BIN_WIDTH-2:0], 1'b0};
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // Sticky truncation flag for the conversion in progress. When the
    // digit count is lossless the carry can never be 1, and this folds away.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_shifting && w_carry && !LOSSLESS) begin
            r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: written only on the final shift, so a conversion
    // cut short by reset never reaches the outputs, and the last result
    // stays visible after the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else if (w_shifting && w_last) begin
            o_bcd      <= w_acc_next;
            o_overflow <= !LOSSLESS && (r_ovf || w_carry);
        end
    end

`ifdef BIN_TO_BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] w_blank;

    // Digit k is blanked when it and every digit above it are zero. The
    // ones digit is never blanked so that a value of zero still shows "0".
    always_comb begin
        logic zero_run;
        w_blank  = '0;
        zero_run = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (w_acc_next[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            w_blank[k] = zero_run;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_blank <= '0;
        end else if (w_shifting && w_last) begin
            o_blank <= w_blank;
        end
    end
`endif

endmodule
